output_sample_buffer: RTL and testbench
=======================================

Name: output_sample_buffer

Overview:
- Output-side counterpart of the input sample register in the LMS filter datapath.
- Accepts full-precision accumulator results from the MAC filter block, one per valid pulse.
- Rescales each result to a Q1.15 output sample and buffers it in a small FIFO.
- Drains samples to a downstream sink over a valid/ready stream with a registered output stage.

Parameters:
- ACC_W, 32, width of the signed accumulator input from the MAC block.
- DATA_W, 16, width of the signed output sample.
- FRAC_SHIFT, 15, arithmetic right shift applied to the accumulator before narrowing.
- DEPTH, 8, storage array entries; must be a power of 2 and at least 2.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- en, input, 1, write-side enable; when low, y_valid is ignored.
- y_in, input, ACC_W, signed accumulator result from the MAC filter.
- y_valid, input, 1, y_in is valid this cycle; there is no backpressure to the MAC block.
- m_data, output, DATA_W, output sample; registered.
- m_valid, output, 1, m_data is valid; registered.
- m_ready, input, 1, sink accepts m_data this cycle.
- level, output, ADDR_W+1, array occupancy plus m_valid (range 0..DEPTH+1).
- full, output, 1, array occupancy == DEPTH.
- drop_cnt, output, 8, saturating count of dropped writes.
- sat_flag, output, 1, sticky saturation indicator.

Behaviour:
- Reset:
  - Clock and reset: single clk domain; reset_n low asynchronously clears all state.
  - Reset values: m_data=0, m_valid=0, level=0, full=0, drop_cnt=0, sat_flag=0, read and write pointers=0.
  - Array contents are not reset.
  - Reset mid-stream discards all held samples; there is no partial recovery.
- Conversion:
  - s = y_in >>> FRAC_SHIFT (sign-preserving).
  - Narrowing to DATA_W follows the Optional Feature rule.
  - Conversion is combinational ahead of the array write.
- Write: occurs at an edge when en=1, y_valid=1, and the array is not full, or the array is full but a pop occurs at the same edge.
  - Stores the converted sample at wr_ptr.
  - wr_ptr increments modulo DEPTH (natural wrap).
- Drop:
  - Condition: en=1, y_valid=1, array full, no pop at the same edge.
  - Effect: sample discarded; drop_cnt increments and saturates at 255.
  - en=0 with y_valid=1 is not a drop.
- Pop: occurs at an edge when the array is non-empty and (m_valid=0 or m_ready=1).
  - Loads m_data from rd_ptr; m_valid=1.
  - rd_ptr increments modulo DEPTH.
- Handshake:
  - Transfer happens on an edge where m_valid=1 and m_ready=1.
  - If that transfer has no accompanying pop, m_valid goes 0.
  - While m_valid=1 and m_ready=0, m_data and m_valid are held stable.
- Latency:
  - A write at edge N into an empty block gives m_valid=1 after edge N+1 (2-cycle y_valid-to-m_valid).
  - No bypass path.
- Simultaneous write and pop:
  - Array occupancy unchanged.
  - Both pointers advance.
  - This is legal at both empty+1 and full.
- Empty array: a write alone at edge N cannot pop until edge N+1; there is no same-cycle read of the written data.
- Sustained throughput: one sample per cycle with m_ready held at 1.
- level/full: derived from registered state only; they reflect the post-edge values.

Optional Feature:
- Macro: OUT_SATURATE_EN.
- Defined:
  - s is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. [-32768, 32767] at default widths.
  - sat_flag sets to 1 whenever an accepted write was clamped.
  - sat_flag stays 1 until reset.
- Undefined:
  - The output sample is s[DATA_W-1:0], so wrap-around.
  - sat_flag is tied to 0.

Test Plan:
1. Reset_n low mid-stream with level=5 -> all outputs 0 asynchronously; after release, the first write of y_in=32'h0000_8000 gives m_data=16'h0001 with m_valid=1 two cycles later.
2. m_ready=1, write y_in=k<<15 for k=1..20, one per cycle -> m_data sequence 1..20 in order, no gaps after initial latency, drop_cnt=0.
3. m_ready=0, 12 consecutive writes at DEPTH=8 -> level=9, full=1, drop_cnt=3; then m_ready=1 -> the first 9 samples emerge in order.
4. Full array, m_ready=1 and write in the same cycle -> write accepted, drop_cnt unchanged, level stays 9.
5. en=0 with y_valid=1 for 4 cycles -> level unchanged, drop_cnt unchanged.
6. y_in=32'h4000_0000 -> with OUT_SATURATE_EN: m_data=16'h7FFF, sat_flag=1; without it: m_data=16'h8000, sat_flag=0. y_in=32'hC000_0000 with OUT_SATURATE_EN: m_data=16'h8000.

Source files
------------

// File: rtl/output_sample_buffer.sv
// Rescales MAC accumulator results to Q1.15 samples and streams them out through a small FIFO.
// Optional macro OUT_SATURATE_EN clamps out-of-range samples instead of wrapping them.
module output_sample_buffer #(
  parameter int ACC_W      = 32,
  parameter int DATA_W     = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [ACC_W-1:0]  y_in,
  input  logic              y_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic [7:0]        drop_cnt,
  output logic              sat_flag
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic signed [ACC_W-1:0] shifted;
  logic [DATA_W-1:0]       sample;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q, m_valid_d;
  logic [7:0]        drop_q, drop_d;
  logic              pop, wr, drop;

  assign shifted = $signed(y_in) >>> FRAC_SHIFT;

`ifdef OUT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(longint'(1) << (DATA_W-1)));

  logic clamped;
  logic sat_q;

  always_comb begin
    clamped = 1'b0;
    sample  = DATA_W'(shifted);
    if (shifted > SAT_MAX) begin
      clamped = 1'b1;
      sample  = DATA_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      clamped = 1'b1;
      sample  = DATA_W'(SAT_MIN);
    end
  end

  // Sticky: only clamps on writes that actually land in the array count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sat_q <= 1'b0;
    else if (wr && clamped)
      sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`else
  assign sample   = DATA_W'(shifted);
  assign sat_flag = 1'b0;
`endif

  // A pop refills the output register whenever it is empty or being drained this edge.
  assign pop  = (cnt_q != '0) && (!m_valid_q || m_ready);
  assign full = (cnt_q == FULL_CNT);
  assign wr   = en && y_valid && (!full || pop);
  assign drop = en && y_valid && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    m_valid_d = m_valid_q;
    if (pop)
      m_valid_d = 1'b1;
    else if (m_valid_q && m_ready)
      m_valid_d = 1'b0;

    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (wr)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        m_data_q <= mem[rd_ptr_q];
      end
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      drop_q    <= drop_d;
    end
  end

  // Storage is left unreset; at full, a same-edge write and pop share an address and the read sees old data.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr_q] <= sample;
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign level    = cnt_q + {{ADDR_W{1'b0}}, m_valid_q};
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_output_sample_buffer.sv
// Scoreboard bench for output_sample_buffer: expected samples are queued on accepted writes
// and compared when the sink takes them; occupancy/flags follow a small cycle model.
module tb_output_sample_buffer;

  localparam int ACC_W  = 32;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic [ACC_W-1:0]  y_in = '0;
  logic              y_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic [ADDR_W:0]   level;
  logic              full;
  logic [7:0]        drop_cnt;
  logic              sat_flag;

  int checks = 0;
  int failures = 0;

  logic [15:0] expQ[$];
  int          modelArr = 0;
  logic        modelValid = 1'b0;
  int          modelDrops = 0;
  logic        modelSat = 1'b0;

  output_sample_buffer #(
    .ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC_SHIFT(15), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .y_in(y_in), .y_valid(y_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .full(full), .drop_cnt(drop_cnt), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] convert(input logic [31:0] y, output logic clampedOut);
    logic signed [31:0] s;
    s = $signed(y) >>> 15;
    clampedOut = 1'b0;
`ifdef OUT_SATURATE_EN
    if (s > 32767) begin
      clampedOut = 1'b1;
      return 16'h7FFF;
    end
    if (s < -32768) begin
      clampedOut = 1'b1;
      return 16'h8000;
    end
`endif
    return s[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    modelArr = 0;
    modelValid = 1'b0;
    modelDrops = 0;
    modelSat = 1'b0;
  endtask

  // Called at a falling edge: drives one cycle of inputs, advances the model, checks after the next rising edge.
  task automatic applyStimulus(input logic enI, input logic yvI, input logic [31:0] yI, input logic readyI);
    logic pop, wr, c;
    logic [15:0] d;
    en = enI;
    y_valid = yvI;
    y_in = yI;
    m_ready = readyI;
    #1;
    if (modelValid && m_ready) begin
      if (expQ.size() == 0)
        checkOutput("sb_underflow", 32'd1, 32'd0);
      else
        checkOutput("m_data", {16'd0, m_data}, {16'd0, expQ.pop_front()});
    end
    pop = (modelArr > 0) && (!modelValid || m_ready);
    wr  = en && y_valid && ((modelArr < DEPTH) || pop);
    if (en && y_valid && !wr && modelDrops < 255)
      modelDrops++;
    if (wr) begin
      d = convert(y_in, c);
      expQ.push_back(d);
      if (c)
        modelSat = 1'b1;
    end
    if (pop)
      modelValid = 1'b1;
    else if (modelValid && m_ready)
      modelValid = 1'b0;
    modelArr = modelArr + (wr ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("m_valid", {31'd0, m_valid}, {31'd0, modelValid});
    checkOutput("level", {28'd0, level}, modelArr + (modelValid ? 1 : 0));
    checkOutput("full", {31'd0, full}, {31'd0, (modelArr == DEPTH)});
    checkOutput("drop_cnt", {24'd0, drop_cnt}, modelDrops);
    checkOutput("sat_flag", {31'd0, sat_flag}, {31'd0, modelSat});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expQ.size() > 0; i++)
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("drained", expQ.size(), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m_data"}, {16'd0, m_data}, 32'd0);
    checkOutput({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    checkOutput({tag, "_level"}, {28'd0, level}, 32'd0);
    checkOutput({tag, "_full"}, {31'd0, full}, 32'd0);
    checkOutput({tag, "_drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
    checkOutput({tag, "_sat_flag"}, {31'd0, sat_flag}, 32'd0);
  endtask

  initial begin
    logic [15:0] expHi;
    logic [15:0] expLo;
    logic        expSat;
`ifdef OUT_SATURATE_EN
    expHi = 16'h7FFF;
    expSat = 1'b1;
`else
    expHi = 16'h8000;
    expSat = 1'b0;
`endif
    expLo = 16'h8000;

    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Build up occupancy, then yank reset asynchronously mid-cycle.
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b1, 1'b1, 32'(k) << 15, 1'b0);
    checkOutput("level_before_reset", {28'd0, level}, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b1, 32'h0000_8000, 1'b0);
    checkOutput("latency_n", {31'd0, m_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("latency_n1_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("latency_n1_data", {16'd0, m_data}, 32'h0001);
    drain();

    // Sustained stream with the sink always ready.
    for (int k = 1; k <= 20; k++)
      applyStimulus(1'b1, 1'b1, 32'(k) << 15, 1'b1);
    drain();
    checkOutput("stream_drops", {24'd0, drop_cnt}, 32'd0);

    // Overfill with the sink stalled.
    for (int k = 1; k <= 12; k++)
      applyStimulus(1'b1, 1'b1, 32'(100 + k) << 15, 1'b0);
    checkOutput("overfill_level", {28'd0, level}, 32'd9);
    checkOutput("overfill_full", {31'd0, full}, 32'd1);
    checkOutput("overfill_drops", {24'd0, drop_cnt}, 32'd3);

    applyStimulus(1'b1, 1'b1, 32'(200) << 15, 1'b1);
    checkOutput("full_wr_pop_level", {28'd0, level}, 32'd9);
    checkOutput("full_wr_pop_drops", {24'd0, drop_cnt}, 32'd3);

    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 1'b1, 32'(300 + k) << 15, 1'b0);
    checkOutput("en_low_level", {28'd0, level}, 32'd9);
    checkOutput("en_low_drops", {24'd0, drop_cnt}, 32'd3);
    drain();

    // Out-of-range samples.
    applyStimulus(1'b1, 1'b1, 32'h4000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("conv_hi_data", {16'd0, m_data}, {16'd0, expHi});
    checkOutput("conv_hi_sat", {31'd0, sat_flag}, {31'd0, expSat});
    drain();
    applyStimulus(1'b1, 1'b1, 32'hC000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("conv_lo_data", {16'd0, m_data}, {16'd0, expLo});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
